fp_vec_accumulator: RTL and testbench
=====================================

Name: fp_vec_accumulator

Overview:
- Sequential reduction stage that sums a stream of LEN single-precision floats into one result.
- Sits directly upstream of the combinational fp_adder:
  - drives its two operand inputs (running sum and incoming element);
  - registers its sum output each cycle.
- Result is presented on a valid/ready output port.
- Also guards the adder against operand cases it cannot handle: zero operands and exact cancellation.

Parameters:
N, 32, operand/result width (IEEE-754 single layout: sign[N-1], exp[30:23], mantissa[22:0]; only 32 supported)
LEN, 8, number of elements per reduction (2..255); count register width = clog2(LEN+1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  in_data holds a valid element
in_ready  output  1  block accepts an element this cycle
in_data  input  N  element to accumulate
add_a  output  N  to fp_adder a: current accumulator value
add_b  output  N  to fp_adder b: in_data
add_sum  input  N  from fp_adder result (combinational)
out_valid  output  1  out_data holds the completed sum
out_ready  input  1  consumer accepts result
out_data  output  N  completed sum (registered accumulator)
busy  output  1  high while a reduction is in progress (count != 0 or state OUT)

Behaviour:
- One clock; reset is synchronous and active-high.
  - rst sampled high at a rising edge: state=IDLE, acc=0, count=0.
  - Resulting outputs: out_valid=0, in_ready=1, busy=0, out_data=0.
  - Reset mid-reduction or in OUT discards the partial or pending sum; no output is produced.
- Accept = in_valid & in_ready. add_a=acc and add_b=in_data are combinational and always driven.
- Zero = bits[30:0]==0, sign ignored.
- Update on accept, in priority order:
  1. First element (count==0): acc <= in_data, no addition.
  2. in_data is zero: acc unchanged.
  3. acc is zero: acc <= in_data.
  4. acc[30:0]==in_data[30:0] and signs differ: acc <= 32'h0 (+0.0); the adder must never see this case.
  5. Otherwise: acc <= add_sum.
- Special values: no handling of Inf/NaN/denormals; all non-zero operands are treated as normalized.
- States:
  - IDLE: in_ready=1, count==0.
    - Accept -> ACC with count=1.
    - If LEN were 1 -> OUT; LEN>=2 is required, so this does not occur.
  - ACC: in_ready=1.
    - Accept increments count.
    - Accept with count==LEN-1 -> OUT (acc updated that same edge).
    - No accept: hold.
  - OUT: in_ready=0, out_valid=1, out_data=acc, stable until handshake.
    - out_valid & out_ready -> IDLE, count=0, acc=0.
    - The next element is accepted no earlier than the following cycle.
- Latency:
  - out_valid rises the cycle after the LEN-th accept.
  - Minimum reduction period is LEN+1 cycles (LEN accepts + 1 output cycle with out_ready=1).
- in_valid may drop between elements (gaps); count and acc hold.
- in_data is ignored when in_ready=0.
- busy = (state != IDLE).

Test Plan:
- LEN=8, in_valid=1 continuously, eight x 0x3F800000 (1.0), out_ready=1 -> out_valid pulses in cycle 9 after first accept, out_data=0x41000000 (8.0), in_ready=0 in that cycle only.
- LEN=4, elements 0x3F800000, 0x40000000, 0x40400000, 0x40800000 (1,2,3,4) -> out_data=0x41200000 (10.0).
- LEN=4, elements 0x40A00000 (5), 0xC0000000 (-2), 0x00000000, 0x3F800000 (1) -> zero bypassed, out_data=0x40800000 (4.0).
- LEN=4, elements 0x3FC00000, 0xBFC00000 (cancellation -> +0), then 0x40000000, 0x3F800000 -> out_data=0x40400000 (3.0); the adder result must not be used in the cancel cycle.
- Backpressure and gaps:
  - LEN=4, in_valid toggling 1/0, out_ready held 0 for 3 cycles after out_valid.
  - Required: out_valid and out_data stable, in_ready=0 throughout; after out_ready=1, IDLE next cycle.
- Reset mid-reduction: rst=1 after 2 of 4 accepts -> next cycle count=0, busy=0, in_ready=1; a following full 4-element run of 1.0 yields 0x40800000.

Source files
------------

// File: rtl/fp_vec_accumulator.sv
// Sequential reduction of LEN single-precision floats through an external
// combinational fp_adder; shields the adder from zero operands and exact cancellation.
module fp_vec_accumulator #(
  parameter int N   = 32,
  parameter int LEN = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  input  logic [N-1:0] add_sum,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_OUT
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [N-1:0]   acc;
  logic [N-1:0]   acc_nx;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_nx;

  logic accept;
  logic in_zero;
  logic acc_zero;
  logic cancel;

  assign accept   = in_valid & in_ready;
  assign in_zero  = (in_data[N-2:0] == '0);
  assign acc_zero = (acc[N-2:0] == '0);
  assign cancel   = (acc[N-2:0] == in_data[N-2:0]) && (acc[N-1] != in_data[N-1]);

  assign add_a    = acc;
  assign add_b    = in_data;
  assign out_data = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      acc   <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      count <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_ACC;
      S_ACC:   if (accept && (count == LAST)) state_nx = S_OUT;
      S_OUT:   if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state != S_OUT);
    out_valid = (state == S_OUT);
    busy      = (state != S_IDLE);
  end

  // Operand screening happens before the adder result is ever selected, so the
  // adder's output for zero or cancelling operands is never used.
  always_comb begin
    acc_nx   = acc;
    count_nx = count;
    if ((state == S_OUT) && out_ready) begin
      acc_nx   = '0;
      count_nx = '0;
    end else if (accept) begin
      count_nx = count + CW'(1);
      if (count == '0)
        acc_nx = in_data;
      else if (in_zero)
        acc_nx = acc;
      else if (acc_zero)
        acc_nx = in_data;
      else if (cancel)
        acc_nx = '0;
      else
        acc_nx = add_sum;
    end
  end

endmodule

// File: tb/tb_fp_vec_accumulator.sv
// Bench for fp_vec_accumulator: LEN=8 and LEN=4 instances, each fed by a real-valued
// adder model and checked every cycle against a sum-of-reals reduction model.
module tb_fp_vec_accumulator;

  logic        clk;
  logic        rst;
  logic        in_valid  [2];
  logic [31:0] in_data   [2];
  logic        out_ready [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic [31:0] out_data  [2];
  logic        busy      [2];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] a);
    real r;
    int  e;
    if (a[30:0] == 31'd0) return 0.0;
    r = 1.0 + real'(a[22:0]) / 8388608.0;
    e = int'(a[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return a[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic        s;
    int          e;
    real         r;
    logic [31:0] m;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    r = s ? -x : x;
    e = 127;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0) begin r = r * 2.0; e--; end
    m = 32'($rtoi((r - 1.0) * 8388608.0));
    return {s, 8'(e), m[22:0]};
  endfunction

  // Adder stand-in: correct for normal operands, poisoned for the cases the
  // accumulator must keep away from it.
  function automatic logic [31:0] adder_model(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return 32'h7FC00000;
    if (a[30:0] == b[30:0] && a[31] != b[31]) return 32'h7FC00000;
    return r2f(f2r(a) + f2r(b));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = (g == 0) ? 8 : 4;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;

    fp_vec_accumulator #(.N(32), .LEN(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_sum   (add_sum),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );

    always_comb add_sum = adder_model(add_a, add_b);

    int  m_cnt  = 0;
    bit  m_out  = 1'b0;
    bit  chk_en = 1'b0;
    real m_sum  = 0.0;

    always @(negedge clk) begin
      if (chk_en) begin
        chk($sformatf("u%0d.out_valid", g), 32'(out_valid[g]), 32'(m_out));
        chk($sformatf("u%0d.in_ready", g), 32'(in_ready[g]), 32'(!m_out));
        chk($sformatf("u%0d.busy", g), 32'(busy[g]), 32'(m_out || m_cnt != 0));
        chk($sformatf("u%0d.out_data", g), out_data[g], r2f(m_sum));
        chk($sformatf("u%0d.add_a", g), add_a, r2f(m_sum));
        chk($sformatf("u%0d.add_b", g), add_b, in_data[g]);
      end
      if (rst) begin
        m_cnt  = 0;
        m_out  = 1'b0;
        m_sum  = 0.0;
        chk_en = 1'b1;
      end else if (m_out) begin
        if (out_ready[g]) begin
          m_out = 1'b0;
          m_cnt = 0;
          m_sum = 0.0;
        end
      end else if (in_valid[g]) begin
        m_sum = m_sum + f2r(in_data[g]);
        m_cnt++;
        if (m_cnt == L) m_out = 1'b1;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run4(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                      input logic [31:0] e3, input bit gaps, input int hold,
                      input logic [31:0] exp, input string tag);
    logic [31:0] el [4];
    bit          seen;
    el[0] = e0; el[1] = e1; el[2] = e2; el[3] = e3;
    out_ready[1] = (hold == 0);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        in_valid[1] = 1'b0;
        in_data[1]  = 32'h12345678;
        next_cycle();
      end
      in_valid[1] = 1'b1;
      in_data[1]  = el[i];
      next_cycle();
    end
    in_valid[1] = 1'b0;
    in_data[1]  = 32'h0;
    seen = 1'b0;
    for (int w = 0; w < 4 && !seen; w++) begin
      @(negedge clk);
      if (out_valid[1]) seen = 1'b1;
      else next_cycle();
    end
    chk({tag, "_valid_seen"}, 32'(seen), 32'd1);
    chk({tag, "_result"}, out_data[1], exp);
    for (int h = 0; h < hold; h++) begin
      next_cycle();
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(out_valid[1]), 32'd1);
      chk({tag, "_hold_ready"}, 32'(in_ready[1]), 32'd0);
      chk({tag, "_hold_data"}, out_data[1], exp);
    end
    next_cycle();
    if (hold != 0) begin
      out_ready[1] = 1'b1;
      next_cycle();
    end
    out_ready[1] = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_valid"}, 32'(out_valid[1]), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy[1]), 32'd0);
    chk({tag, "_idle_ready"}, 32'(in_ready[1]), 32'd1);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      in_valid[g]  = 1'b0;
      in_data[g]   = 32'h0;
      out_ready[g] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", 32'(out_valid[0]), 32'd0);
    chk("reset_ready", 32'(in_ready[0]), 32'd1);
    chk("reset_busy", 32'(busy[0]), 32'd0);
    chk("reset_data", out_data[0], 32'h0);
    next_cycle();

    // LEN=8, eight 1.0 back to back; result visible in the ninth cycle only
    out_ready[0] = 1'b1;
    in_data[0]   = 32'h3F800000;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) next_cycle();
      in_valid[0] = (k <= 9);
      @(negedge clk);
      chk($sformatf("len8_valid_c%0d", k), 32'(out_valid[0]), 32'(k == 9));
      chk($sformatf("len8_ready_c%0d", k), 32'(in_ready[0]), 32'(k != 9));
      if (k == 9) chk("len8_result", out_data[0], 32'h41000000);
    end
    next_cycle();
    out_ready[0] = 1'b0;

    run4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 1'b0, 0, 32'h41200000, "sum1234");
    run4(32'h40A00000, 32'hC0000000, 32'h00000000, 32'h3F800000, 1'b0, 0, 32'h40800000, "zero_skip");
    run4(32'h3FC00000, 32'hBFC00000, 32'h40000000, 32'h3F800000, 1'b0, 0, 32'h40400000, "cancel");
    run4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 1'b1, 3, 32'h41200000, "backpr");

    // Reset after two of four accepts discards the partial sum
    in_data[1] = 32'h3F800000;
    in_valid[1] = 1'b1;
    next_cycle();
    next_cycle();
    in_valid[1] = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy[1]), 32'd0);
    chk("rst_mid_ready", 32'(in_ready[1]), 32'd1);
    chk("rst_mid_data", out_data[1], 32'h0);
    next_cycle();
    run4(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 0, 32'h40800000, "after_rst");

    repeat (2) next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
